// File: rtl/cycle_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with combinational strobes.
// Optional memory wait timeout enabled by defining SEQ_TIMEOUT_EN.
//
// state  | meaning
// FETCH  | request instruction, load IR on mem_ready
// DECODE | latch opcode, pick EXEC or HALT
// EXEC   | resolve branch/jump/NOP or route to MEM/WB
// MEM    | data access, wait for mem_ready
// WB     | register write-back and PC increment
// HALT   | idle until reset
module cycle_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       ir_load,
    output logic       pc_en,
    output logic       pc_sel,
    output logic       reg_wb,
    output logic       halted,
    output logic       timeout_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be in 1..255");
    end

    state_t     cur_state;
    state_t     next_state;
    logic [3:0] op_q;
    logic       mem_access;
    logic       timeout_hit;
    logic       is_mem_op;
    logic       is_load;
    logic       is_alu;
    logic       is_branch;
    logic       is_jump;

    always_comb begin
        is_mem_op = op_q inside {4'b1010, 4'b1011, 4'b1100, 4'b1101};
        is_load   = op_q inside {4'b1010, 4'b1100};
        is_alu    = op_q inside {4'b1111, 4'b1000, 4'b1001};
        is_branch = op_q inside {4'b0100, 4'b0101, 4'b0110};
        is_jump   = (op_q == 4'b0001);
    end

    assign mem_access = (cur_state == S_FETCH) || (cur_state == S_MEM);

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_FETCH: begin
                if (mem_ready)
                    next_state = S_DECODE;
                else if (timeout_hit)
                    next_state = S_HALT;
            end
            S_DECODE: next_state = (opcode == 4'b0000) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (is_mem_op)
                    next_state = S_MEM;
                else if (is_alu)
                    next_state = S_WB;
                else
                    next_state = S_FETCH;
            end
            S_MEM: begin
                if (mem_ready)
                    next_state = is_load ? S_WB : S_FETCH;
                else if (timeout_hit)
                    next_state = S_HALT;
            end
            S_WB:    next_state = S_FETCH;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= S_FETCH;
            op_q      <= 4'b0000;
        end else begin
            cur_state <= next_state;
            if (cur_state == S_DECODE)
                op_q <= opcode;
        end
    end

    // Reset gates every output so strobes vanish the moment reset rises.
    always_comb begin
        mem_req = 1'b0;
        ir_load = 1'b0;
        pc_en   = 1'b0;
        pc_sel  = 1'b0;
        reg_wb  = 1'b0;
        halted  = 1'b0;
        if (!reset) begin
            case (cur_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_load = mem_ready;
                end
                S_EXEC: begin
                    if (is_branch) begin
                        pc_en  = 1'b1;
                        pc_sel = branch_taken;
                    end else if (is_jump) begin
                        pc_en  = 1'b1;
                        pc_sel = 1'b1;
                    end else if (!is_mem_op && !is_alu) begin
                        pc_en  = 1'b1;
                        pc_sel = 1'b0;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    pc_en   = mem_ready && !is_load;
                end
                S_WB: begin
                    reg_wb = 1'b1;
                    pc_en  = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = reset ? 3'd0 : cur_state;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    logic [7:0] wait_cnt;
    logic       timeout_q;

    assign timeout_hit = mem_access && !mem_ready && (wait_cnt == TIMEOUT_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            if ((next_state == S_FETCH && cur_state != S_FETCH) ||
                (next_state == S_MEM && cur_state != S_MEM))
                wait_cnt <= 8'd0;
            else if (mem_access && !mem_ready && wait_cnt != 8'hFF)
                wait_cnt <= wait_cnt + 8'd1;
            if (timeout_hit)
                timeout_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_q && !reset;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: per-cycle expected outputs go through a scoreboard queue.
module tb_cycle_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       branch_taken;
    logic       mem_req, ir_load, pc_en, pc_sel, reg_wb, halted, timeout_err;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];
    string      tag_q[$];

    cycle_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk(clk),
        .reset(reset),
        .opcode(opcode),
        .mem_ready(mem_ready),
        .branch_taken(branch_taken),
        .mem_req(mem_req),
        .ir_load(ir_load),
        .pc_en(pc_en),
        .pc_sel(pc_sel),
        .reg_wb(reg_wb),
        .halted(halted),
        .timeout_err(timeout_err),
        .state(state)
    );

    always #5 clk = ~clk;

    wire [9:0] obs = {state, mem_req, ir_load, pc_en, pc_sel, reg_wb, halted, timeout_err};

    // {state, mem_req, ir_load, pc_en, pc_sel, reg_wb, halted, timeout_err}
    function automatic logic [9:0] ev(input logic [2:0] st, input logic mr, input logic il,
                                      input logic pe, input logic ps, input logic rw,
                                      input logic hl, input logic te);
        return {st, mr, il, pe, ps, rw, hl, te};
    endfunction

    task automatic expect_out(input logic [9:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic check_now();
        logic [9:0] e;
        string t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %b expected an entry", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %b expected %b", t, obs, e);
            end
        end
    endtask

    // Called at a falling edge: drive one cycle of inputs, check, advance to the next falling edge.
    task automatic step(input logic mr, input logic bt, input logic [3:0] op,
                        input logic [9:0] e, input string t);
        mem_ready    = mr;
        branch_taken = bt;
        opcode       = op;
        expect_out(e, t);
        #2;
        check_now();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        reset     = 1'b1;
        mem_ready = 1'b1;
        expect_out(ev(3'd0, 0, 0, 0, 0, 0, 0, 0), "reset_outputs");
        #2;
        check_now();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fetch_decode(input logic [3:0] op, input logic bt);
        step(1'b1, bt, op, ev(3'd0, 1, 1, 0, 0, 0, 0, 0), "fetch");
        step(1'b1, bt, op, ev(3'd1, 0, 0, 0, 0, 0, 0, 0), "decode");
    endtask

    logic [3:0] t_op  [9] = '{4'h5, 4'h5, 4'h4, 4'h6, 4'h1, 4'h2, 4'h3, 4'h7, 4'hE};
    logic       t_bt  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       t_sel [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        reset        = 1'b1;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        opcode       = 4'h0;
        @(negedge clk);
        reset_pulse();

        // ALU op 1111, zero-wait memory
        fetch_decode(4'hF, 1'b0);
        step(1'b1, 1'b0, 4'hF, ev(3'd2, 0, 0, 0, 0, 0, 0, 0), "alu_exec");
        step(1'b1, 1'b0, 4'hF, ev(3'd4, 0, 0, 1, 0, 1, 0, 0), "alu_wb");

        // load 1100 with three wait cycles in MEM
        fetch_decode(4'hC, 1'b0);
        step(1'b1, 1'b0, 4'hC, ev(3'd2, 0, 0, 0, 0, 0, 0, 0), "load_exec");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 4'hC, ev(3'd3, 1, 0, 0, 0, 0, 0, 0), "load_mem_wait");
        step(1'b1, 1'b0, 4'hC, ev(3'd3, 1, 0, 0, 0, 0, 0, 0), "load_mem_ack");
        step(1'b1, 1'b0, 4'hC, ev(3'd4, 0, 0, 1, 0, 1, 0, 0), "load_wb");

        // branches, jump and NOPs: three cycles each
        for (int i = 0; i < 9; i++) begin
            fetch_decode(t_op[i], t_bt[i]);
            step(1'b1, t_bt[i], t_op[i], ev(3'd2, 0, 0, 1, t_sel[i], 0, 0, 0), "pc_exec");
        end

        // store 1011 zero-wait
        fetch_decode(4'hB, 1'b0);
        step(1'b1, 1'b0, 4'hB, ev(3'd2, 0, 0, 0, 0, 0, 0, 0), "store_exec");
        step(1'b1, 1'b0, 4'hB, ev(3'd3, 1, 0, 1, 0, 0, 0, 0), "store_mem");

        // ALU op 1001
        fetch_decode(4'h9, 1'b1);
        step(1'b1, 1'b1, 4'h9, ev(3'd2, 0, 0, 0, 0, 0, 0, 0), "alu9_exec");
        step(1'b1, 1'b1, 4'h9, ev(3'd4, 0, 0, 1, 0, 1, 0, 0), "alu9_wb");

        // reset in the middle of a store's MEM phase
        fetch_decode(4'hD, 1'b0);
        step(1'b1, 1'b0, 4'hD, ev(3'd2, 0, 0, 0, 0, 0, 0, 0), "store13_exec");
        mem_ready = 1'b0;
        expect_out(ev(3'd3, 1, 0, 0, 0, 0, 0, 0), "store13_mem_wait");
        #2;
        check_now();
        #1;
        reset = 1'b1;
        expect_out(ev(3'd0, 0, 0, 0, 0, 0, 0, 0), "async_reset_drop");
        #1;
        check_now();
        @(negedge clk);
        mem_ready = 1'b1;
        expect_out(ev(3'd0, 0, 0, 0, 0, 0, 0, 0), "no_pc_en_in_reset");
        #2;
        check_now();
        @(negedge clk);
        reset = 1'b0;
        fetch_decode(4'h1, 1'b0);
        step(1'b1, 1'b0, 4'h1, ev(3'd2, 0, 0, 1, 1, 0, 0, 0), "jump_after_reset");

        // halt: HALT from cycle 3, held with memory ready
        fetch_decode(4'h0, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b1, 4'h0, ev(3'd5, 0, 0, 0, 0, 0, 1, 0), "halt_hold");
        reset_pulse();
        step(1'b0, 1'b0, 4'h0, ev(3'd0, 1, 0, 0, 0, 0, 0, 0), "fetch_after_halt");
        reset_pulse();

`ifdef SEQ_TIMEOUT_EN
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 4'hF, ev(3'd0, 1, 0, 0, 0, 0, 0, 0), "timeout_wait");
        step(1'b0, 1'b0, 4'hF, ev(3'd5, 0, 0, 0, 0, 0, 1, 1), "timeout_halt");
        step(1'b1, 1'b0, 4'hF, ev(3'd5, 0, 0, 0, 0, 0, 1, 1), "timeout_sticky");
        reset_pulse();
        for (int i = 0; i < 15; i++)
            step(1'b0, 1'b0, 4'hF, ev(3'd0, 1, 0, 0, 0, 0, 0, 0), "rescue_wait");
        step(1'b1, 1'b0, 4'hF, ev(3'd0, 1, 1, 0, 0, 0, 0, 0), "rescue_ready");
        step(1'b1, 1'b0, 4'hF, ev(3'd1, 0, 0, 0, 0, 0, 0, 0), "rescue_decode");
`else
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'b0, 4'hF, ev(3'd0, 1, 0, 0, 0, 0, 0, 0), "endless_wait");
        step(1'b1, 1'b0, 4'hF, ev(3'd0, 1, 1, 0, 0, 0, 0, 0), "late_ready");
        step(1'b1, 1'b0, 4'hF, ev(3'd1, 0, 0, 0, 0, 0, 0, 0), "late_decode");
`endif
        step(1'b1, 1'b0, 4'hF, ev(3'd2, 0, 0, 0, 0, 0, 0, 0), "final_exec");
        step(1'b1, 1'b0, 4'hF, ev(3'd4, 0, 0, 1, 0, 1, 0, 0), "final_wb");
        step(1'b0, 1'b0, 4'hF, ev(3'd0, 1, 0, 0, 0, 0, 0, 0), "final_fetch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, the number of wait cycles allowed for mem_ready before a timeout (range 1..255).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  4  instruction opcode, sampled in DECODE.
REQ-005 mem_ready  input  1  memory acknowledge for the current mem_req.
REQ-006 branch_taken  input  1  ALU compare result, sampled in EXEC for branch opcodes.
REQ-007 mem_req  output  1  memory access request (fetch or data).
REQ-008 ir_load  output  1  instruction register load strobe.
REQ-009 pc_en  output  1  PC update strobe.
REQ-010 pc_sel  output  1  PC source: 1 = branch/jump target, 0 = PC+1; meaningful only when pc_en=1.
REQ-011 reg_wb  output  1  register-file write strobe.
REQ-012 halted  output  1  high while in HALT.
REQ-013 timeout_err  output  1  sticky memory-timeout flag.
REQ-014 state  output  3  current state encoding, for debug.

Function
REQ-015 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to HALT on the next edge.
REQ-016 FETCH: mem_req=1; on mem_ready=1, ir_load=1 in the same cycle and next state is DECODE; otherwise remain in FETCH.
REQ-017 DECODE: latch opcode into internal op_q; opcode 0000 -> HALT, all other opcodes -> EXEC.
REQ-018 EXEC, for op_q in {1010,1011,1100,1101}: next state is MEM.
REQ-019 EXEC, for op_q in {1111,1000,1001}: next state is WB.
REQ-020 EXEC, for op_q in {0100,0101,0110}: pc_en=1 and pc_sel=branch_taken; next state is FETCH.
REQ-021 EXEC, for op_q 0001 (jump): pc_en=1 and pc_sel=1; next state is FETCH.
REQ-022 EXEC, for op_q in {0010,0011,0111,1110}: treat as NOP, with pc_en=1 and pc_sel=0; next state is FETCH.
REQ-023 MEM: mem_req=1 until mem_ready; on mem_ready, loads (1010,1100) go to WB; stores (1011,1101) assert pc_en=1, pc_sel=0 and go to FETCH.
REQ-024 WB: reg_wb=1, pc_en=1, pc_sel=0 for exactly one cycle; next state is FETCH.
REQ-025 HALT: all strobes 0 and halted=1; HALT is left only by reset.
REQ-026 Strobes SHALL be combinational from the current state, op_q, mem_ready and branch_taken, with no glitch-sensitive use; each strobe is 1 for at most one cycle per instruction, except mem_req.
REQ-027 Instruction latency with zero-wait memory: ALU op 4 cycles, load 5, store 4, branch/jump/NOP 3, halt 2 to reach HALT.
REQ-028 Wait counter (8 bits): cleared on entering FETCH or MEM; increments each cycle mem_req=1 and mem_ready=0; saturates, never wraps.
REQ-029 When the counter equals MEM_TIMEOUT and mem_ready=0, set timeout_err and go to HALT on the next edge; mem_ready=1 in that same cycle wins (normal progress, no error).

Reset
REQ-030 While reset=1: state=FETCH, op_q=0, counter=0, timeout_err=0, and all outputs are forced to 0 regardless of state.
REQ-031 Reset asserted mid-instruction SHALL abandon the instruction with no further strobes; after release, a new FETCH begins on the first edge.

Configuration
REQ-032 Macro SEQ_TIMEOUT_EN: when defined, REQ-028 and REQ-029 apply; when undefined, there is no counter, the block waits indefinitely for mem_ready, and timeout_err is tied to 0.

Verification
REQ-033 Opcode 1111 with mem_ready held at 1 -> ir_load at cycle 1, reg_wb and pc_en at cycle 4, back in FETCH at cycle 5.
REQ-034 Opcode 1100 with mem_ready low for 3 MEM cycles -> mem_req high for 4 MEM cycles, reg_wb one cycle later, total 8 cycles.
REQ-035 Opcode 0101 with branch_taken=1, then 0101 with branch_taken=0 -> pc_en with pc_sel=1, then pc_en with pc_sel=0, 3 cycles each.
REQ-036 Opcode 0000 -> halted=1 from cycle 3 and held for 20 cycles while mem_req stays 0; reset pulse -> state=0.
REQ-037 With SEQ_TIMEOUT_EN and MEM_TIMEOUT=15, mem_ready stuck at 0 in FETCH -> timeout_err=1, state=5 after 16 cycles; repeating with mem_ready=1 on the 16th cycle -> no error.
REQ-038 Reset asserted during MEM of opcode 1101 -> mem_req drops asynchronously and no pc_en occurs; after release, FETCH resumes.
